// File: rtl/muldiv_unit_pkg.sv
// Shared decode/execute definitions: mulOp encoding and the muldiv FSM states.
// Imported by decode and by the muldiv execute unit.
package common;

  typedef logic [3:0] mulop_t;

  localparam mulop_t MULOP_MUL   = 4'b0000;
  localparam mulop_t MULOP_DIV   = 4'b0100;
  localparam mulop_t MULOP_DIVU  = 4'b0101;
  localparam mulop_t MULOP_REM   = 4'b0110;
  localparam mulop_t MULOP_REMU  = 4'b0111;
  localparam mulop_t MULOP_MULW  = 4'b1000;
  localparam mulop_t MULOP_DIVW  = 4'b1100;
  localparam mulop_t MULOP_DIVUW = 4'b1101;
  localparam mulop_t MULOP_REMW  = 4'b1110;
  localparam mulop_t MULOP_REMUW = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_e;

  function automatic logic op_word(input mulop_t op);
    return op[3];
  endfunction

  function automatic logic op_div(input mulop_t op);
    return op[2];
  endfunction

  function automatic logic op_rem(input mulop_t op);
    return op[1];
  endfunction

  function automatic logic op_uns(input mulop_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Command/result handshake bundle between EX issue logic and the muldiv unit.
// master: issues in_valid/mul_op/src_a/src_b, takes result with out_ready.
// slave: the unit; returns in_ready, out_valid, result.
interface muldiv_unit_if #(
  parameter int XLEN = 64
);
  import common::*;

  logic            in_valid;
  logic            in_ready;
  mulop_t          mul_op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid,
    output mul_op,
    output src_a,
    output src_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result
  );

  modport slave (
    input  in_valid,
    input  mul_op,
    input  src_a,
    input  src_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result
  );

endinterface

// File: rtl/muldiv_unit_step.sv
// One iteration of the muldiv datapath (combinational).
// Ports: acc_i/sh_i/opnd_i state in, div_i selects divide; acc_o/sh_o/qbit_o next state.
module muldiv_unit_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] sh_i,
  input  logic [XLEN-1:0] opnd_i,
  input  logic            div_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] sh_o,
  output logic            qbit_o
);
  import common::*;

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Shifted partial remainder needs one extra bit:
  // a divisor above 2^(XLEN-1) can still be <= it.
  assign rem_sh = {acc_i, sh_i[XLEN-1]};
  assign diff   = rem_sh - {1'b0, opnd_i};

  always_comb begin
    acc_o  = acc_i;
    sh_o   = sh_i;
    qbit_o = 1'b0;
    if (div_i) begin
      qbit_o = ~diff[XLEN];
      acc_o  = qbit_o ? diff[XLEN-1:0]
                      : rem_sh[XLEN-1:0];
      sh_o   = {sh_i[XLEN-2:0], qbit_o};
    end else begin
      // Shift-add: opnd_i is the multiplier, LSB first.
      acc_o = acc_i + (opnd_i[0] ? sh_i : '0);
      sh_o  = {sh_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M execute unit: mul/div/divu/rem/remu and W forms, 1 bit/cycle.
// Ports: clk, reset (async high), flush, io (slave: command in, result out).
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  muldiv_unit_if.slave io
);
  import common::*;

  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN);

  localparam logic [XLEN-1:0] MIN_D =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W =
    {{(H+1){1'b1}}, {(H-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            word_q, word_d;
  logic            div_q, div_d;
  logic            rem_q, rem_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;

  function automatic logic [XLEN-1:0] sxw(
    input logic [H-1:0] v
  );
    return {{H{v[H-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zxw(
    input logic [H-1:0] v
  );
    return {{H{1'b0}}, v};
  endfunction

  logic            in_word, in_div;
  logic            in_rem, in_uns;
  logic [XLEN-1:0] ext_a, ext_b, a_ws;
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            b_zero, ovf, fast;
  logic [XLEN-1:0] fast_res;

  assign in_word = op_word(io.mul_op);
  assign in_div  = op_div(io.mul_op);
  assign in_rem  = op_rem(io.mul_op);
  assign in_uns  = op_uns(io.mul_op);

  assign ext_a = !in_word ? io.src_a
               : in_uns   ? zxw(io.src_a[H-1:0])
                          : sxw(io.src_a[H-1:0]);
  assign ext_b = !in_word ? io.src_b
               : in_uns   ? zxw(io.src_b[H-1:0])
                          : sxw(io.src_b[H-1:0]);

  // Dividend as the W result format wants it.
  assign a_ws = in_word ? sxw(io.src_a[H-1:0])
                        : io.src_a;

  assign sgn_a = in_div & ~in_uns & ext_a[XLEN-1];
  assign sgn_b = in_div & ~in_uns & ext_b[XLEN-1];
  assign mag_a = sgn_a ? -ext_a : ext_a;
  assign mag_b = sgn_b ? -ext_b : ext_b;

  assign b_zero = (ext_b == '0);
  assign ovf    = ~in_uns & (&ext_b) &
                  (ext_a == (in_word ? MIN_W : MIN_D));
  assign fast   = in_div & (b_zero | ovf);

  always_comb begin
    fast_res = '0;
    if (b_zero) begin
      fast_res = in_rem ? a_ws : '1;
    end else begin
      // MIN / -1: quotient is the dividend itself.
      fast_res = in_rem ? '0 : a_ws;
    end
  end

  logic [XLEN-1:0] st_acc, st_sh;
  logic            st_qbit;

  muldiv_unit_step #(
    .XLEN(XLEN)
  ) u_step (
    .acc_i (acc_q),
    .sh_i  (sh_q),
    .opnd_i(opb_q),
    .div_i (div_q),
    .acc_o (st_acc),
    .sh_o  (st_sh),
    .qbit_o(st_qbit)
  );

  logic [XLEN-1:0] q_fix, r_fix;
  logic [XLEN-1:0] pick, fix_res;

  assign q_fix = negq_q ? -sh_q : sh_q;
  assign r_fix = negr_q ? -acc_q : acc_q;
  assign pick  = !div_q ? acc_q
               : rem_q  ? r_fix : q_fix;
  assign fix_res = word_q ? sxw(pick[H-1:0])
                          : pick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opb_d   = opb_q;
    res_d   = res_q;
    word_d  = word_q;
    div_d   = div_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid && !flush) begin
          word_d = in_word;
          div_d  = in_div;
          rem_d  = in_rem;
          negq_d = sgn_a ^ sgn_b;
          negr_d = sgn_a;
          cnt_d  = in_word ? CW'(H - 1)
                           : CW'(XLEN - 1);
          acc_d  = '0;
          if (in_div) begin
            // W dividend sits in the top half so
            // its MSB is the first bit shifted out.
            sh_d  = in_word
                  ? {mag_a[H-1:0], {H{1'b0}}}
                  : mag_a;
            opb_d = mag_b;
          end else begin
            sh_d  = ext_a;
            opb_d = ext_b;
          end
          if (fast) begin
            res_d   = fast_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = st_acc;
        sh_d  = st_sh;
        if (!div_q) begin
          opb_d = opb_q >> 1;
        end
        if (cnt_q == '0) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIXUP: begin
        res_d   = fix_res;
        state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      word_q  <= 1'b0;
      div_q   <= 1'b0;
      rem_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      word_q  <= word_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.result    = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a result scoreboard.
// Expected results are queued at issue and checked on each output handshake.
module tb_muldiv_unit;
  import common::*;

  logic clk;
  logic reset;
  logic flush;

  muldiv_unit_if io ();

  muldiv_unit dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .io   (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  logic [63:0] exp_q[$];
  string       name_q[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected result: got %h want none",
                   io.result);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          chk(n, io.result, e);
        end
      end
    end
  endtask

  // Called at #1 after a clock edge with the unit idle.
  task automatic run_op(input string nm,
                        input mulop_t op,
                        input logic [63:0] a,
                        input logic [63:0] b,
                        input logic [63:0] exp,
                        input int lat);
    int k;
    logic busy_rdy;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    chk({nm, " idle rdy"}, 64'(io.in_ready), 64'd1);
    io.in_valid = 1'b1;
    io.mul_op   = op;
    io.src_a    = a;
    io.src_b    = b;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.src_a    = 64'hDEAD_BEEF_0BAD_F00D;
    io.src_b    = 64'h0123_4567_89AB_CDEF;
    k = 1;
    busy_rdy = 1'b0;
    while (!io.out_valid && k < 200) begin
      if (io.in_ready) busy_rdy = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    chk({nm, " latency"}, 64'(k), 64'(lat));
    chk({nm, " busy rdy"}, 64'(busy_rdy), 64'd0);
    if (io.out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [63:0] held;
  logic        bad;

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    flush       = 1'b0;
    io.in_valid = 1'b0;
    io.mul_op   = MULOP_MUL;
    io.src_a    = '0;
    io.src_b    = '0;
    io.out_ready = 1'b1;
    fork
      monitor();
    join_none

    #12;
    chk("reset in_ready", 64'(io.in_ready), 64'd1);
    chk("reset out_valid", 64'(io.out_valid), 64'd0);
    chk("reset result", io.result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("mul 7*-3", MULOP_MUL, 64'd7,
           64'hFFFF_FFFF_FFFF_FFFD,
           64'hFFFF_FFFF_FFFF_FFEB, 66);
    run_op("div 42/0", MULOP_DIV, 64'd42, 64'd0,
           64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("rem 42/0", MULOP_REM, 64'd42, 64'd0,
           64'd42, 1);
    run_op("divuw 5/0", MULOP_DIVUW, 64'd5, 64'd0,
           64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("div min/-1", MULOP_DIV,
           64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1);
    run_op("rem min/-1", MULOP_REM,
           64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("divw min/-1", MULOP_DIVW,
           64'h0000_0000_8000_0000,
           64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("divuw ffffffff/2", MULOP_DIVUW,
           64'h0000_0000_FFFF_FFFF, 64'd2,
           64'h0000_0000_7FFF_FFFF, 34);
    run_op("remw -7%2", MULOP_REMW,
           64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_op("mulw", MULOP_MULW,
           64'h0000_0001_0000_0003,
           64'h0000_0000_8000_0000,
           64'hFFFF_FFFF_8000_0000, 34);
    run_op("div -100/7", MULOP_DIV,
           64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
           64'hFFFF_FFFF_FFFF_FFF2, 66);
    run_op("rem -100%7", MULOP_REM,
           64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
           64'hFFFF_FFFF_FFFF_FFFE, 66);
    run_op("divu max/16", MULOP_DIVU,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
           64'h0FFF_FFFF_FFFF_FFFF, 66);
    run_op("remu max%16", MULOP_REMU,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
           64'hF, 66);
    run_op("divu big", MULOP_DIVU,
           64'h8000_0000_0000_0001,
           64'h8000_0000_0000_0000, 64'd1, 66);

    // Backpressure: hold the result for 10 cycles.
    io.out_ready = 1'b0;
    run_op("mul bp", MULOP_MUL, 64'h1234, 64'h10,
           64'h1_2340, 66);
    held = io.result;
    bad  = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!io.out_valid || io.result !== held) bad = 1'b1;
    end
    chk("bp stable", 64'(bad), 64'd0);
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1;
    io.mul_op    = MULOP_DIVU;
    io.src_a     = 64'd9;
    io.src_b     = 64'd3;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    chk("handoff no accept", 64'(io.in_ready), 64'd1);
    chk("handoff valid low", 64'(io.out_valid), 64'd0);
    run_op("divu 9/3", MULOP_DIVU, 64'd9, 64'd3,
           64'd3, 66);

    // Flush a divide on edge 20 with a competing command.
    io.in_valid = 1'b1;
    io.mul_op   = MULOP_DIV;
    io.src_a    = 64'd1000;
    io.src_b    = 64'd3;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    flush       = 1'b1;
    io.in_valid = 1'b1;
    io.mul_op   = MULOP_MUL;
    io.src_a    = 64'd3;
    io.src_b    = 64'd3;
    @(posedge clk);
    #1;
    flush       = 1'b0;
    io.in_valid = 1'b0;
    chk("flush idle", 64'(io.in_ready), 64'd1);
    chk("flush no valid", 64'(io.out_valid), 64'd0);
    bad = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (io.out_valid) bad = 1'b1;
    end
    chk("flush stays quiet", 64'(bad), 64'd0);
    run_op("remu 100%7", MULOP_REMU, 64'd100, 64'd7,
           64'd2, 66);

    // Async reset in the middle of CALC.
    io.in_valid = 1'b1;
    io.mul_op   = MULOP_MUL;
    io.src_a    = 64'd5;
    io.src_b    = 64'd5;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async rst in_ready", 64'(io.in_ready), 64'd1);
    chk("async rst out_valid", 64'(io.out_valid), 64'd0);
    chk("async rst result", io.result, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op("mul after rst", MULOP_MUL, 64'd11,
           64'd13, 64'd143, 66);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
